// File: rtl/yuv2rgb.sv
// JFIF full-range YCbCr to 8-bit RGB converter, 3-stage pipeline.
// Global enable from downstream hold; strobes ride along with data.
module yuv2rgb #(
  parameter int DW = 8,
  parameter int MW = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [2:0][DW-1:0] yuv,
  input  logic               yuv_valid,
  output logic               yuv_hold,
  input  logic               frame_valid_in,
  input  logic               line_valid_in,
  output logic [2:0][DW-1:0] rgb24,
  output logic               rgb24_valid,
  input  logic               rgb24_hold,
  output logic               frame_valid_out,
  output logic               line_valid_out
);

  localparam int SW = DW + 11;

  localparam logic signed [DW:0] OFS = 9'sd128;
  localparam logic signed [SW-1:0] RND = 19'sd128;
  localparam logic signed [SW-1:0] C_R = 19'sd359;
  localparam logic signed [SW-1:0] C_GB = 19'sd88;
  localparam logic signed [SW-1:0] C_GR = 19'sd183;
  localparam logic signed [SW-1:0] C_B = 19'sd454;

  if (MW != 8) begin : g_mw_chk
    $error("yuv2rgb: only MW == 8 is supported");
  end

  logic                 en;
  logic [2:0]           vld;
  logic [2:0]           fvd;
  logic [2:0]           lvd;
  logic [DW-1:0]        y0;
  logic [DW-1:0]        y1;
  logic signed [DW:0]   cbd;
  logic signed [DW:0]   crd;
  logic signed [SW-1:0] pr;
  logic signed [SW-1:0] pgb;
  logic signed [SW-1:0] pgr;
  logic signed [SW-1:0] pb;
  logic signed [SW-1:0] ybase;
  logic signed [SW-1:0] sr;
  logic signed [SW-1:0] sg;
  logic signed [SW-1:0] sb;
  logic signed [SW-1:0] rs;
  logic signed [SW-1:0] gs;
  logic signed [SW-1:0] bs;

  function automatic logic [DW-1:0] clamp(
    input logic signed [SW-1:0] v
  );
    logic [DW-1:0] o;
    if (v[SW-1]) o = '0;
    else if (|v[SW-2:DW]) o = '1;
    else o = v[DW-1:0];
    return o;
  endfunction

  assign en       = !rgb24_hold;
  assign yuv_hold = rgb24_hold;

  assign rgb24_valid     = vld[2];
  assign frame_valid_out = fvd[2];
  assign line_valid_out  = lvd[2];

  // Valid and frame/line strobes shift together on every enabled cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld <= '0;
      fvd <= '0;
      lvd <= '0;
    end else if (en) begin
      vld <= {vld[1:0], yuv_valid};
      fvd <= {fvd[1:0], frame_valid_in};
      lvd <= {lvd[1:0], line_valid_in};
    end
  end

  // S0: capture luma and re-centre the chroma pair around zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y0  <= '0;
      cbd <= '0;
      crd <= '0;
    end else if (en && yuv_valid) begin
      y0  <= yuv[0];
      cbd <= $signed({1'b0, yuv[1]}) - OFS;
      crd <= $signed({1'b0, yuv[2]}) - OFS;
    end
  end

  // S1: chroma products in 8 fraction bits, luma delayed to match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y1  <= '0;
      pr  <= '0;
      pgb <= '0;
      pgr <= '0;
      pb  <= '0;
    end else if (en && vld[0]) begin
      y1  <= y0;
      pr  <= crd * C_R;
      pgb <= cbd * C_GB;
      pgr <= crd * C_GR;
      pb  <= cbd * C_B;
    end
  end

  assign ybase = SW'({y1, {MW{1'b0}}});
  assign sr    = ybase + pr + RND;
  assign sg    = ybase - pgb - pgr + RND;
  assign sb    = ybase + pb + RND;
  assign rs    = sr >>> MW;
  assign gs    = sg >>> MW;
  assign bs    = sb >>> MW;

  // S2: round, floor-shift, clamp to the component range and register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rgb24 <= '0;
    end else if (en && vld[1]) begin
      rgb24[0] <= clamp(rs);
      rgb24[1] <= clamp(gs);
      rgb24[2] <= clamp(bs);
    end
  end

endmodule

// File: tb/tb_yuv2rgb.sv
// Bench for yuv2rgb: directed vector table, streaming with
// backpressure, strobe alignment and asynchronous reset.
module tb_yuv2rgb;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [2:0][7:0] yuv;
  logic           yuv_valid;
  logic           yuv_hold;
  logic           frame_valid_in;
  logic           line_valid_in;
  logic [2:0][7:0] rgb24;
  logic           rgb24_valid;
  logic           rgb24_hold;
  logic           frame_valid_out;
  logic           line_valid_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  yuv2rgb #(.DW(8), .MW(8)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .yuv             (yuv),
    .yuv_valid       (yuv_valid),
    .yuv_hold        (yuv_hold),
    .frame_valid_in  (frame_valid_in),
    .line_valid_in   (line_valid_in),
    .rgb24           (rgb24),
    .rgb24_valid     (rgb24_valid),
    .rgb24_hold      (rgb24_hold),
    .frame_valid_out (frame_valid_out),
    .line_valid_out  (line_valid_out)
  );

  typedef struct {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input vec_t v);
    return {v.b, v.g, v.r};
  endfunction

  function automatic logic [23:0] act_rgb();
    return {rgb24[2], rgb24[1], rgb24[0]};
  endfunction

  task automatic put_pix(input vec_t v);
    yuv[0] = v.y;
    yuv[1] = v.cb;
    yuv[2] = v.cr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [23:0] snap;
    logic        snap_v;
    logic        prev_hold;
    int sent;
    int got;
    int hcnt;
    int extra;
    logic [15:0] vv;
    logic [15:0] fv;
    logic [15:0] lv;
    logic [15:0] hd;
    logic [2:0]  mv;
    logic [2:0]  mf;
    logic [2:0]  ml;

    tv[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
    tv[1] = '{8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0};
    tv[2] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255};
    tv[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0};
    tv[4] = '{8'd200, 8'd128, 8'd128, 8'd200, 8'd200, 8'd200};
    tv[5] = '{8'd100, 8'd200, 8'd50,  8'd0,   8'd131, 8'd228};
    tv[6] = '{8'd150, 8'd100, 8'd180, 8'd223, 8'd122, 8'd100};
    tv[7] = '{8'd50,  8'd60,  8'd70,  8'd0,   8'd115, 8'd0};
    tv[8] = '{8'd30,  8'd140, 8'd120, 8'd19,  8'd32,  8'd51};

    yuv            = '0;
    yuv_valid      = 1'b0;
    frame_valid_in = 1'b0;
    line_valid_in  = 1'b0;
    rgb24_hold     = 1'b0;

    #2;
    chk("reset_flags",
        {29'd0, rgb24_valid, frame_valid_out, line_valid_out}, 32'd0);
    chk("reset_rgb", {8'd0, act_rgb()}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // single-beat vectors: latency 3, one cycle wide
    for (int i = 0; i < 9; i++) begin
      put_pix(tv[i]);
      yuv_valid = 1'b1;
      tick();
      yuv_valid = 1'b0;
      chk($sformatf("lat1_v%0d", i), {31'd0, rgb24_valid}, 32'd0);
      tick();
      chk($sformatf("lat2_v%0d", i), {31'd0, rgb24_valid}, 32'd0);
      tick();
      chk($sformatf("lat3_v%0d", i), {31'd0, rgb24_valid}, 32'd1);
      chk($sformatf("rgb_v%0d", i), {8'd0, act_rgb()},
          {8'd0, exp_rgb(tv[i])});
      tick();
      chk($sformatf("width_v%0d", i), {31'd0, rgb24_valid}, 32'd0);
    end

    // 8-beat stream, 2-cycle hold while beat 4 is presented
    sent = 0;
    got = 0;
    hcnt = 0;
    snap = '0;
    snap_v = 1'b0;
    prev_hold = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      rgb24_hold = (sent == 4 && hcnt < 2);
      if (rgb24_hold) hcnt++;
      yuv_valid = (sent < 8);
      put_pix(tv[(sent < 8) ? sent + 1 : 0]);
      @(negedge clk);
      chk("stream_yuv_hold", {31'd0, yuv_hold}, {31'd0, rgb24_hold});
      if (prev_hold) begin
        chk("stream_frozen", {7'd0, rgb24_valid, act_rgb()},
            {7'd0, snap_v, snap});
      end
      if (rgb24_valid && !rgb24_hold) begin
        chk($sformatf("stream_pix%0d", got), {8'd0, act_rgb()},
            {8'd0, exp_rgb(tv[got + 1])});
        got++;
      end
      snap = act_rgb();
      snap_v = rgb24_valid;
      prev_hold = rgb24_hold;
      @(posedge clk);
      if (!rgb24_hold && yuv_valid) sent++;
      #1;
    end
    chk("stream_count", got, 32'd8);
    chk("stream_holds", hcnt, 32'd2);
    yuv_valid = 1'b0;
    rgb24_hold = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rgb24_valid) extra++;
      tick();
    end
    chk("stream_no_dup", extra, 32'd0);

    // strobes with valid gaps and a 2-cycle hold
    vv = 16'b0001_0100_0101_0000;
    fv = 16'b0011_1111_1111_1100;
    lv = 16'b0001_1100_0111_0000;
    hd = 16'b0000_0011_0000_0000;
    mv = '0;
    mf = '0;
    ml = '0;
    put_pix(tv[1]);
    for (int c = 0; c < 16; c++) begin
      yuv_valid      = vv[c];
      frame_valid_in = fv[c];
      line_valid_in  = lv[c];
      rgb24_hold     = hd[c];
      @(negedge clk);
      chk($sformatf("strobe_c%0d", c),
          {29'd0, rgb24_valid, frame_valid_out, line_valid_out},
          {29'd0, mv[2], mf[2], ml[2]});
      @(posedge clk);
      if (!hd[c]) begin
        mv = {mv[1:0], vv[c]};
        mf = {mf[1:0], fv[c]};
        ml = {ml[1:0], lv[c]};
      end
      #1;
    end
    yuv_valid      = 1'b0;
    frame_valid_in = 1'b0;
    line_valid_in  = 1'b0;
    rgb24_hold     = 1'b0;
    for (int c = 0; c < 4; c++) tick();

    // asynchronous reset in the middle of a stream
    put_pix(tv[6]);
    yuv_valid      = 1'b1;
    frame_valid_in = 1'b1;
    line_valid_in  = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("pre_reset_flags",
        {29'd0, rgb24_valid, frame_valid_out, line_valid_out}, 32'd7);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_reset_flags",
        {29'd0, rgb24_valid, frame_valid_out, line_valid_out}, 32'd0);
    chk("async_reset_rgb", {8'd0, act_rgb()}, 32'd0);
    yuv_valid      = 1'b0;
    frame_valid_in = 1'b0;
    line_valid_in  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("post_reset_c%0d", c),
          {5'd0, rgb24_valid, frame_valid_out, line_valid_out,
           act_rgb()}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
